// File: rtl/mem_access_stage.sv
// Data-memory access stage: byte/half/word loads and stores with alignment checks.
// Define DMEM_WAIT_STATES_EN to build the IDLE/WAIT/DONE wait-state FSM; otherwise accesses complete at once.
module mem_access_stage #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] MEM_c,
   input  logic [31:0] MEM_rt_data,
   input  logic        MEM_mem_read,
   input  logic        MEM_mem_write,
   input  logic [1:0]  MEM_size,
   input  logic        MEM_unsigned,
   output logic [31:0] MEM_data_read,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        misalign_sticky
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [AW-1:0] word_idx;
   logic          access;
   logic          bad_align;
   logic          aligned_access;
   logic          complete;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_val;
   logic          misalign_sticky_q;
   logic          misalign_sticky_d;
   logic          unused_bits;

   logic [31:0]   mem_q [DEPTH_WORDS];

   // Upper address bits are deliberately dropped so addresses wrap.
   assign word_idx    = MEM_c[AW+1:2];
   assign unused_bits = ^{MEM_c[31:AW+2], 32'(WAIT_CYCLES)};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      bad_align = 1'b0;
      mem_be    = 4'b1111;
      mem_wdata = MEM_rt_data;
      case (MEM_size)
         2'b00: begin
            mem_be    = 4'b0001 << MEM_c[1:0];
            mem_wdata = {4{MEM_rt_data[7:0]}};
         end
         2'b01: begin
            bad_align = MEM_c[0];
            mem_be    = MEM_c[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{MEM_rt_data[15:0]}};
         end
         default: bad_align = |MEM_c[1:0];
      endcase
   end

   assign access         = MEM_mem_read | MEM_mem_write;
   assign mem_misalign   = access & bad_align;
   assign aligned_access = access & ~bad_align;

   always_comb begin
      rd_word = mem_q[word_idx];
      rd_byte = rd_word[{MEM_c[1:0], 3'b000} +: 8];
      rd_half = MEM_c[1] ? rd_word[31:16] : rd_word[15:0];
      case (MEM_size)
         2'b00:   load_val = {{24{~MEM_unsigned & rd_byte[7]}}, rd_byte};
         2'b01:   load_val = {{16{~MEM_unsigned & rd_half[15]}}, rd_half};
         default: load_val = rd_word;
      endcase
   end

   // A simultaneous read+write is a store, so it returns no load data.
   assign MEM_data_read = (complete & MEM_mem_read & ~MEM_mem_write) ? load_val : 32'd0;
   assign mem_we        = complete & MEM_mem_write & ~reset;

   // NOTE: the data array is intentionally not reset; contents survive reset and the array stays RAM-inferable.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) mem_q[word_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
         end
      end
   end

   assign misalign_sticky_d = misalign_sticky_q | mem_misalign;
   assign misalign_sticky   = misalign_sticky_q;

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock) begin
      if (reset) misalign_sticky_q <= 1'b0;
      else       misalign_sticky_q <= misalign_sticky_d;
   end

`ifdef DMEM_WAIT_STATES_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_e;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_e     state_q;
   state_e     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt holds the wait cycles still owed after the current one; DONE is entered as it reaches 0,
   // giving WAIT_CYCLES stalled cycles followed by the completing DONE cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      complete  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (aligned_access) begin
               if (WAIT_CYCLES == 0) begin
                  complete = 1'b1;
               end else begin
                  mem_stall = 1'b1;
                  cnt_d     = WAIT_LAST;
                  state_d   = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
               end
            end
         end
         S_WAIT: begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DONE;
         end
         S_DONE: begin
            complete = aligned_access;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
`else
   assign mem_stall = 1'b0;
   assign complete  = aligned_access;
`endif

endmodule
